// File: rtl/ram_if_pkg.sv
// Shared definitions for the 8-bit x 64 dual-port RAM initiator.
//   DATA_W_DEF / ADDR_W_DEF : default word and address widths of the RAM
//   WE_WRITE / WE_READ      : levels of the active-low RAM write enable
//   state_e                 : controller state (zero-fill, then normal run)
package ram_if_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 6;

  localparam logic WE_WRITE = 1'b0;
  localparam logic WE_READ  = 1'b1;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

endpackage

// File: rtl/rsp_fifo.sv
// Synchronous FIFO for read responses. Storage is not reset; only the
// pointers and the occupancy count are cleared by sclr.
//   clk, sclr          : clock, synchronous active-high clear
//   push, push_data    : write one entry (ignored when full without a pop)
//   pop                : remove head entry (ignored when empty)
//   pop_data           : head entry (valid while !empty)
//   count, empty, full : occupancy status
module rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   sclr,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/ram_req_master.sv
// Initiator for one port of the 8x64 dual-port RAM. Zero-fills the RAM after
// clear, then turns a valid/ready request stream into registered RAM port
// cycles and returns read data, in order, through a response FIFO.
//   clk, sclr                              : clock, synchronous active-high clear
//   req_valid/req_ready/req_write/addr/wdata : request stream
//   rsp_valid/rsp_ready/rsp_rdata          : response stream (reads only)
//   ram_addr/ram_din/ram_we/ram_dout       : RAM port (ram_we active-low)
//   init_done                              : zero-fill complete
//
// state   | meaning
// ST_INIT | writing zero to every address, requests blocked
// ST_RUN  | servicing requests
module ram_req_master
  import ram_if_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int RSP_DEPTH = 4,
  parameter bit INIT_EN   = 1'b1
) (
  input  logic              clk,
  input  logic              sclr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              init_done
);

  localparam int CNT_W  = $clog2(RSP_DEPTH) + 1;
  localparam int CRED_W = CNT_W + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              init_done_q, init_done_d;
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_din_q, ram_din_d;
  logic              ram_we_q, ram_we_d;
  // bit 0: read issued to the RAM port this cycle; bit 1: RAM dout valid now
  logic [1:0]        rd_pipe_q, rd_pipe_d;

  logic [CNT_W-1:0]  fifo_count;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_empty, fifo_full;
  logic [CRED_W-1:0] credit;
  logic              req_accept, rsp_pop;

  // Every accepted read owns a FIFO slot from acceptance on, so the FIFO
  // cannot overflow regardless of how long the consumer stalls.
  assign credit = CRED_W'(fifo_count) + CRED_W'(rd_pipe_q[0]) + CRED_W'(rd_pipe_q[1]);

  assign req_ready  = (state_q == ST_RUN) & init_done_q & (credit < CRED_W'(RSP_DEPTH));
  assign req_accept = req_valid & req_ready;

  assign rsp_valid = ~fifo_empty;
  assign rsp_rdata = rsp_valid ? fifo_head : '0;
  assign rsp_pop   = rsp_valid & rsp_ready;

  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign ram_we    = ram_we_q;
  assign init_done = init_done_q;

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = (state_q == ST_RUN);
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    ram_we_d    = WE_READ;
    rd_pipe_d   = {rd_pipe_q[0], 1'b0};
    case (state_q)
      ST_INIT: begin
        ram_we_d   = WE_WRITE;
        ram_din_d  = '0;
        ram_addr_d = init_cnt_q;
        init_cnt_d = init_cnt_q + ADDR_W'(1);
        // last address stops the fill rather than wrapping
        if (init_cnt_q == '1) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (req_accept) begin
          ram_addr_d   = req_addr;
          ram_din_d    = req_wdata;
          ram_we_d     = req_write ? WE_WRITE : WE_READ;
          rd_pipe_d[0] = ~req_write;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      state_q     <= INIT_EN ? ST_INIT : ST_RUN;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      ram_we_q    <= WE_READ;
      rd_pipe_q   <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      ram_we_q    <= ram_we_d;
      rd_pipe_q   <= rd_pipe_d;
    end
  end

  rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_W)
  ) u_rsp_fifo (
    .clk       (clk),
    .sclr      (sclr),
    .push      (rd_pipe_q[1]),
    .push_data (ram_dout),
    .pop       (rsp_pop),
    .pop_data  (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

endmodule

// File: tb/tb_ram_req_master.sv
module tb_ram_req_master;

  logic       clk = 1'b0;
  logic       sclr;
  logic       req_valid, req_ready, req_write;
  logic [5:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_rdata;
  logic [5:0] ram_addr;
  logic [7:0] ram_din;
  logic       ram_we;
  logic [7:0] ram_dout;
  logic       init_done;

  int n_chk = 0;
  int n_err = 0;

  logic       fill_ff;
  logic [7:0] mem [64];

  always #5 clk = ~clk;

  ram_req_master #(
    .DATA_W    (8),
    .ADDR_W    (6),
    .RSP_DEPTH (4),
    .INIT_EN   (1'b1)
  ) dut (
    .clk       (clk),
    .sclr      (sclr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_we    (ram_we),
    .ram_dout  (ram_dout),
    .init_done (init_done)
  );

  // RAM model: registered read, write on ram_we low. fill_ff preloads 0xFF
  // so that the zero-fill is observable.
  always @(posedge clk) begin
    if (fill_ff) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'hFF;
    end else if (!ram_we) begin
      mem[ram_addr] <= ram_din;
    end
    ram_dout <= mem[ram_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expects to be called at a negedge right after sclr is released.
  task automatic check_init();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      chk("init_we", ram_we, 0);
      chk("init_addr", ram_addr, i);
      chk("init_din", ram_din, 0);
      chk("init_done_lo", init_done, 0);
      chk("init_ready_lo", req_ready, 0);
      chk("init_rsp_lo", rsp_valid, 0);
    end
    @(negedge clk);
    chk("init_done_hi", init_done, 1);
    chk("post_init_we", ram_we, 1);
    chk("post_init_ready", req_ready, 1);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic do_req(input logic wr, input logic [5:0] a, input logic [7:0] d);
    int waited;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    waited    = 0;
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) chk("req_ready_timeout", 0, 1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    int acc;
    sclr = 1'b1; fill_ff = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    fill_ff = 1'b0;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_ram_we", ram_we, 1);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_din", ram_din, 0);
    chk("rst_init_done", init_done, 0);
    sclr = 1'b0;
    check_init();

    // write then read same address
    do_req(1'b1, 6'h10, 8'hA5);
    chk("wr_we", ram_we, 0);
    chk("wr_addr", ram_addr, 6'h10);
    chk("wr_din", ram_din, 8'hA5);
    do_req(1'b0, 6'h10, 8'h00);
    chk("rd_we", ram_we, 1);
    chk("rd_lat0", rsp_valid, 0);
    @(negedge clk);
    chk("rd_lat1", rsp_valid, 0);
    @(negedge clk);
    chk("rd_lat2_valid", rsp_valid, 1);
    chk("rd_lat2_data", rsp_rdata, 8'hA5);
    @(negedge clk);
    chk("rd_single", rsp_valid, 0);

    // untouched top address was zero-filled
    do_req(1'b0, 6'h3F, 8'h00);
    repeat (2) @(negedge clk);
    chk("rd3f_valid", rsp_valid, 1);
    chk("rd3f_data", rsp_rdata, 8'h00);
    @(negedge clk);

    for (int i = 0; i < 8; i++) do_req(1'b1, 6'(i), 8'(8'h20 + i));
    @(negedge clk);

    // back-to-back reads with rsp_ready=1
    for (int c = 0; c <= 10; c++) begin
      if (c > 0) @(negedge clk);
      if (c < 8) begin
        chk("b2b_ready", req_ready, 1);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 6'(c);
      end else begin
        req_valid = 1'b0;
      end
      if (c == 2) chk("b2b_empty", rsp_valid, 0);
      if (c >= 3) begin
        chk("b2b_valid", rsp_valid, 1);
        chk("b2b_data", rsp_rdata, 8'h20 + (c - 3));
      end
    end
    @(negedge clk);
    chk("b2b_done", rsp_valid, 0);

    // backpressure: credit caps outstanding reads at 4
    rsp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 6'(acc);
      if (req_ready) acc++;
      if (c >= 6) begin
        chk("bp_valid", rsp_valid, 1);
        chk("bp_stable", rsp_rdata, 8'h20);
      end
    end
    req_valid = 1'b0;
    chk("bp_accepted", acc, 4);
    chk("bp_ready_lo", req_ready, 0);
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_valid", rsp_valid, 1);
      chk("drain_data", rsp_rdata, 8'h20 + k);
      @(negedge clk);
    end
    chk("drain_empty", rsp_valid, 0);
    chk("drain_ready", req_ready, 1);

    // clear with 2 responses queued and 2 reads in flight
    rsp_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = 6'(c);
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("pre_clr_valid", rsp_valid, 1);
    sclr = 1'b1;
    @(negedge clk);
    sclr = 1'b0;
    rsp_ready = 1'b1;
    chk("clr_rsp_valid", rsp_valid, 0);
    chk("clr_ready", req_ready, 0);
    chk("clr_init_done", init_done, 0);
    chk("clr_addr", ram_addr, 0);
    check_init();
    repeat (3) begin
      chk("no_stale", rsp_valid, 0);
      @(negedge clk);
    end
    do_req(1'b0, 6'h05, 8'h00);
    repeat (2) @(negedge clk);
    chk("refill_valid", rsp_valid, 1);
    chk("refill_data", rsp_rdata, 8'h00);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
